// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver slice.
//   PC_W        : width of PC, branch target and redirect address
//   cond_e      : branch condition encodings carried on branchCond
//   state_e     : resolver FSM states
//   redirect_addr() : absolute / PC-relative redirect computation
package branch_resolver_pkg;

  localparam int PC_W = 16;

  typedef enum logic [2:0] {
    COND_JMP  = 3'b000,  // unconditional
    COND_JE   = 3'b001,  // zf
    COND_JNE  = 3'b010,  // ~zf
    COND_JB   = 3'b011,  // cf
    COND_JA   = 3'b100,  // ~zf & ~cf
    COND_JAE  = 3'b101,  // ~cf
    COND_JBE  = 3'b110,  // zf | cf
    COND_RSVD = 3'b111   // never taken
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  // Relative targets are offsets from the instruction after the branch;
  // the sum wraps silently at 2^PC_W.
  function automatic logic [PC_W-1:0] redirect_addr(input logic            rel,
                                                    input logic [PC_W-1:0] target,
                                                    input logic [PC_W-1:0] pc);
    return rel ? (pc + PC_W'(1) + target) : target;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Bundle between decode/compare (master) and the branch resolver (slave).
//   compare side : compareSignal, flagValid, zf, cf
//   request side : branchReq, branchReady, branchCond, branchRel, target, pc
//   redirect     : resolveValid, taken, pcLoad, pcValue
interface branch_resolver_if
  import branch_resolver_pkg::*;
();

  logic            compareSignal;
  logic            flagValid;
  logic            zf;
  logic            cf;
  logic            branchReq;
  logic            branchReady;
  logic [2:0]      branchCond;
  logic            branchRel;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic            resolveValid;
  logic            taken;
  logic            pcLoad;
  logic [PC_W-1:0] pcValue;

  // Driven by decode/compare and fetch-side observers.
  modport master (
    output compareSignal, flagValid, zf, cf,
    output branchReq, branchCond, branchRel, target, pc,
    input  branchReady, resolveValid, taken, pcLoad, pcValue
  );

  // The resolver itself.
  modport slave (
    input  compareSignal, flagValid, zf, cf,
    input  branchReq, branchCond, branchRel, target, pc,
    output branchReady, resolveValid, taken, pcLoad, pcValue
  );

endinterface

// File: rtl/branch_resolver_cond_eval.sv
// Combinational branch condition evaluator.
//   cond_i  : branch condition encoding (cond_e)
//   zf_i    : zero flag
//   cf_i    : carry / unsigned-below flag
//   taken_o : 1 when the condition holds
module branch_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       zf_i,
  input  logic       cf_i,
  output logic       taken_o
);

  always_comb begin
    // NOTE: a default assignment before the case keeps every path driven, so no latch is inferred.
    taken_o = 1'b0;
    case (cond_i)
      COND_JMP:  taken_o = 1'b1;
      COND_JE:   taken_o = zf_i;
      COND_JNE:  taken_o = ~zf_i;
      COND_JB:   taken_o = cf_i;
      COND_JA:   taken_o = ~zf_i & ~cf_i;
      COND_JAE:  taken_o = ~cf_i;
      COND_JBE:  taken_o = zf_i | cf_i;
      default:   taken_o = 1'b0;  // COND_RSVD
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: holds the comparator flags, resolves branch requests
// against them and issues a registered PC redirect to fetch.
//   clk  : clock, all state on rising edge
//   rst  : synchronous, active-high reset
//   br   : slave side of branch_resolver_if (compare flags, branch request,
//          registered resolveValid/taken/pcLoad/pcValue redirect)
module branch_resolver
  import branch_resolver_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  branch_resolver_if.slave   br
);

  state_e          state_q;
  logic [2:0]      cond_q;
  logic            zf_q;
  logic            cf_q;
  logic            cmp_pending_q;
  logic            ready_q;
  logic            resolve_valid_q;
  logic            taken_q;
  logic            pc_load_q;
  logic [PC_W-1:0] pc_value_q;

  logic       eval_zf;
  logic       eval_cf;
  logic [2:0] eval_cond;
  logic       eval_taken;
  logic       accept;
  logic       resolve_now;

  always_comb begin
    // Fresh flags arriving this cycle always win over the stored copy.
    eval_zf   = br.flagValid ? br.zf : zf_q;
    eval_cf   = br.flagValid ? br.cf : cf_q;
    // In IDLE the request is evaluated straight off the bus; in WAIT the
    // latched condition is re-evaluated once the flags land.
    eval_cond = (state_q == ST_IDLE) ? br.branchCond : cond_q;
    accept    = ready_q & br.branchReq;
    // Unconditional/reserved branches never depend on flags, so they never stall.
    resolve_now = (br.branchCond == COND_JMP) || (br.branchCond == COND_RSVD) ||
                  !cmp_pending_q || br.flagValid;
  end

  branch_cond_eval u_cond_eval (
    .cond_i  (eval_cond),
    .zf_i    (eval_zf),
    .cf_i    (eval_cf),
    .taken_o (eval_taken)
  );

  // NOTE: all state updates use non-blocking assignments, and the synchronous reset is the first branch of the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cond_q          <= 3'b000;
      zf_q            <= 1'b0;
      cf_q            <= 1'b0;
      cmp_pending_q   <= 1'b0;
      ready_q         <= 1'b1;  // mirrors IDLE, so a request can be taken right after reset
      resolve_valid_q <= 1'b0;
      taken_q         <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_value_q      <= '0;
    end else begin
      if (br.flagValid) begin
        zf_q <= br.zf;
        cf_q <= br.cf;
      end

      // A compare issued in the same cycle as a flag return is a new
      // outstanding compare, so set wins over clear.
      if (br.compareSignal) begin
        cmp_pending_q <= 1'b1;
      end else if (br.flagValid) begin
        cmp_pending_q <= 1'b0;
      end

      // Redirect strobes are single-cycle pulses unless set below.
      resolve_valid_q <= 1'b0;
      taken_q         <= 1'b0;
      pc_load_q       <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cond_q     <= br.branchCond;
            pc_value_q <= redirect_addr(br.branchRel, br.target, br.pc);
            ready_q    <= 1'b0;
            if (resolve_now) begin
              state_q         <= ST_RESOLVE;
              resolve_valid_q <= 1'b1;
              taken_q         <= eval_taken;
              pc_load_q       <= eval_taken;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (br.flagValid) begin
            state_q         <= ST_RESOLVE;
            resolve_valid_q <= 1'b1;
            taken_q         <= eval_taken;
            pc_load_q       <= eval_taken;
          end
        end

        ST_RESOLVE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign br.branchReady  = ready_q;
  assign br.resolveValid = resolve_valid_q;
  assign br.taken        = taken_q;
  assign br.pcLoad       = pc_load_q;
  assign br.pcValue      = pc_value_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: a table of flag/request vectors
// with hand-computed outcomes, plus directed sequences for reset, stalling,
// same-cycle flag bypass and reset during a stall.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int tests_run = 0;
  int tests_failed = 0;

  branch_resolver_if bif ();

  branch_resolver dut (
    .clk (clk),
    .rst (rst),
    .br  (bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        zf;
    logic        cf;
    logic [2:0]  cond;
    logic        rel;
    logic [15:0] target;
    logic [15:0] pc;
    logic        exp_taken;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.compareSignal = 1'b0;
    bif.flagValid     = 1'b0;
    bif.zf            = 1'b0;
    bif.cf            = 1'b0;
    bif.branchReq     = 1'b0;
    bif.branchCond    = 3'b000;
    bif.branchRel     = 1'b0;
    bif.target        = '0;
    bif.pc            = '0;
  endtask

  task automatic load_flags(input logic z, input logic c);
    bif.flagValid = 1'b1;
    bif.zf        = z;
    bif.cf        = c;
    tick();
    bif.flagValid = 1'b0;
  endtask

  // Issue a branch that resolves without stalling and check the redirect.
  task automatic do_branch(input string name, input logic [2:0] cond, input logic rel,
                           input logic [15:0] target, input logic [15:0] pc,
                           input logic exp_taken, input logic [15:0] exp_pc);
    bif.branchReq  = 1'b1;
    bif.branchCond = cond;
    bif.branchRel  = rel;
    bif.target     = target;
    bif.pc         = pc;
    check({name, ".ready"}, {31'd0, bif.branchReady}, 32'd1);
    tick();
    bif.branchReq = 1'b0;
    check({name, ".resolveValid"}, {31'd0, bif.resolveValid}, 32'd1);
    check({name, ".taken"},        {31'd0, bif.taken},        {31'd0, exp_taken});
    check({name, ".pcLoad"},       {31'd0, bif.pcLoad},       {31'd0, exp_taken});
    check({name, ".pcValue"},      {16'd0, bif.pcValue},      {16'd0, exp_pc});
    check({name, ".readyBusy"},    {31'd0, bif.branchReady},  32'd0);
    tick();
    check({name, ".pulseEnds"},    {31'd0, bif.resolveValid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"je_rel_back",   1'b1, 1'b0, COND_JE,   1'b1, 16'hFFFE, 16'h0010, 1'b1, 16'h000F};
    vecs[1]  = '{"jne_zf1",       1'b1, 1'b0, COND_JNE,  1'b1, 16'hFFFE, 16'h0010, 1'b0, 16'h000F};
    vecs[2]  = '{"jb_cf1",        1'b0, 1'b1, COND_JB,   1'b0, 16'h1234, 16'h0000, 1'b1, 16'h1234};
    vecs[3]  = '{"jb_cf0",        1'b0, 1'b0, COND_JB,   1'b0, 16'h1234, 16'h0000, 1'b0, 16'h1234};
    vecs[4]  = '{"ja_clear",      1'b0, 1'b0, COND_JA,   1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0100};
    vecs[5]  = '{"ja_zf1",        1'b1, 1'b0, COND_JA,   1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0100};
    vecs[6]  = '{"ja_cf1",        1'b0, 1'b1, COND_JA,   1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0100};
    vecs[7]  = '{"jae_cf1",       1'b0, 1'b1, COND_JAE,  1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0200};
    vecs[8]  = '{"jae_eq",        1'b1, 1'b0, COND_JAE,  1'b0, 16'h0200, 16'h0000, 1'b1, 16'h0200};
    vecs[9]  = '{"jbe_zf1",       1'b1, 1'b0, COND_JBE,  1'b0, 16'h0300, 16'h0000, 1'b1, 16'h0300};
    vecs[10] = '{"jbe_none",      1'b0, 1'b0, COND_JBE,  1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0300};
    vecs[11] = '{"rel_wrap",      1'b0, 1'b0, COND_JMP,  1'b1, 16'h0001, 16'hFFFF, 1'b1, 16'h0001};
    vecs[12] = '{"rsvd",          1'b1, 1'b1, COND_RSVD, 1'b0, 16'h0500, 16'h0000, 1'b0, 16'h0500};
    vecs[13] = '{"jne_rel_fwd",   1'b1, 1'b1, COND_JNE,  1'b1, 16'h0010, 16'h0100, 1'b0, 16'h0111};
    vecs[14] = '{"jmp_rel_fwd",   1'b1, 1'b1, COND_JMP,  1'b1, 16'h0010, 16'h0100, 1'b1, 16'h0111};
    vecs[15] = '{"je_zf0",        1'b0, 1'b1, COND_JE,   1'b0, 16'h0600, 16'h0000, 1'b0, 16'h0600};

    // Reset state.
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst.resolveValid", {31'd0, bif.resolveValid}, 32'd0);
    check("rst.taken",        {31'd0, bif.taken},        32'd0);
    check("rst.pcLoad",       {31'd0, bif.pcLoad},       32'd0);
    check("rst.pcValue",      {16'd0, bif.pcValue},      32'd0);
    rst = 1'b0;

    // JMP absolute straight out of reset.
    do_branch("jmp_abs", COND_JMP, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h0040);

    // Table: load flags with no compare pending, then resolve immediately.
    for (int i = 0; i < 16; i++) begin
      load_flags(vecs[i].zf, vecs[i].cf);
      do_branch(vecs[i].name, vecs[i].cond, vecs[i].rel, vecs[i].target, vecs[i].pc,
                vecs[i].exp_taken, vecs[i].exp_pc);
    end

    // Stall: stored cf=0, compare at cycle 0, JB accepted at cycle 1,
    // flags (cf=1) at cycle 4, resolution at cycle 5.
    load_flags(1'b0, 1'b0);
    bif.compareSignal = 1'b1;                   // cycle 0
    tick();
    bif.compareSignal = 1'b0;                   // cycle 1
    bif.branchReq  = 1'b1;
    bif.branchCond = COND_JB;
    bif.branchRel  = 1'b0;
    bif.target     = 16'h0200;
    check("stall.readyAccept", {31'd0, bif.branchReady}, 32'd1);
    tick();
    // Decode keeps a different request asserted while the resolver is busy;
    // it must be ignored (an accepted JMP would resolve at once).
    bif.branchCond = COND_JMP;
    bif.target     = 16'h0FFF;
    for (int c = 2; c < 4; c++) begin           // cycles 2, 3
      check($sformatf("stall.ready_c%0d", c), {31'd0, bif.branchReady},  32'd0);
      check($sformatf("stall.rv_c%0d", c),    {31'd0, bif.resolveValid}, 32'd0);
      tick();
    end
    bif.branchReq = 1'b0;                       // cycle 4
    bif.flagValid = 1'b1;
    bif.zf        = 1'b0;
    bif.cf        = 1'b1;
    check("stall.ready_c4", {31'd0, bif.branchReady},  32'd0);
    check("stall.rv_c4",    {31'd0, bif.resolveValid}, 32'd0);
    tick();
    bif.flagValid = 1'b0;                       // cycle 5
    check("stall.resolveValid", {31'd0, bif.resolveValid}, 32'd1);
    check("stall.taken",        {31'd0, bif.taken},        32'd1);
    check("stall.pcLoad",       {31'd0, bif.pcLoad},       32'd1);
    check("stall.pcValue",      {16'd0, bif.pcValue},      32'h0200);
    check("stall.ready_c5",     {31'd0, bif.branchReady},  32'd0);
    tick();                                     // cycle 6
    check("stall.ready_c6", {31'd0, bif.branchReady},  32'd1);
    check("stall.rv_c6",    {31'd0, bif.resolveValid}, 32'd0);

    // Same-cycle bypass: stored zf=cf=1 would make JA not taken; fresh
    // zf=cf=0 arrives with the request while a compare is pending.
    load_flags(1'b1, 1'b1);
    bif.compareSignal = 1'b1;
    tick();
    bif.compareSignal = 1'b0;
    bif.flagValid     = 1'b1;
    bif.zf            = 1'b0;
    bif.cf            = 1'b0;
    do_branch("bypass_ja", COND_JA, 1'b0, 16'h0300, 16'h0000, 1'b1, 16'h0300);
    bif.flagValid = 1'b0;

    // Reset while stalled in WAIT; stored zf=1 must be cleared by reset.
    load_flags(1'b1, 1'b0);
    bif.compareSignal = 1'b1;
    tick();
    bif.compareSignal = 1'b0;
    bif.branchReq  = 1'b1;
    bif.branchCond = COND_JE;
    bif.branchRel  = 1'b0;
    bif.target     = 16'h0700;
    tick();
    bif.branchReq = 1'b0;
    check("rstwait.inWait", {31'd0, bif.branchReady}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstwait.noPulse",  {31'd0, bif.resolveValid}, 32'd0);
    check("rstwait.ready",    {31'd0, bif.branchReady},  32'd1);
    check("rstwait.pcValue",  {16'd0, bif.pcValue},      32'd0);
    tick();
    check("rstwait.noLatePulse", {31'd0, bif.resolveValid}, 32'd0);
    do_branch("rstwait.je_zf0", COND_JE, 1'b0, 16'h0400, 16'h0000, 1'b0, 16'h0400);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
